// File: rtl/framebuffer_reader_if.sv
// ---------------------------------------------------------------------------
// framebuffer_reader_if
//
// Bundles the pixel-pipeline handshake and the SRAM read-port signals of the
// framebuffer reader so that they travel together through the hierarchy.
//
// Signals:
//   i_frame_start  1-cycle pulse that restarts the raster scan
//   i_pix_req      consumer asks for the next display pixel
//   o_sram_read    read enable to the SRAM read port
//   o_sram_addr    read address to the SRAM
//   i_sram_data    SRAM read data, valid one cycle after the read
//   o_pix_data     pixel data towards the colour stage
//   o_pix_valid    o_pix_data carries a pixel this cycle
//   o_frame_done   pulse with the last pixel of the frame
//   o_req_err      sticky flag: pixel requested while not scanning
//   i_scroll_y     first framebuffer line of the frame (FB_READER_SCROLL_EN)
//
// Modports:
//   master  the reader itself
//   slave   the surroundings (pixel pipeline + SRAM)
//
// Optional feature macro: FB_READER_SCROLL_EN adds i_scroll_y.
// ---------------------------------------------------------------------------
interface framebuffer_reader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int FB_HEIGHT  = 240
);
    localparam int SCROLL_W = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

    logic                  i_frame_start;
    logic                  i_pix_req;
    logic                  o_sram_read;
    logic [ADDR_WIDTH-1:0] o_sram_addr;
    logic [DATA_WIDTH-1:0] i_sram_data;
    logic [DATA_WIDTH-1:0] o_pix_data;
    logic                  o_pix_valid;
    logic                  o_frame_done;
    logic                  o_req_err;
`ifdef FB_READER_SCROLL_EN
    logic [SCROLL_W-1:0]   i_scroll_y;
`endif

`ifdef FB_READER_SCROLL_EN
    modport master (
        input  i_frame_start, i_pix_req, i_sram_data, i_scroll_y,
        output o_sram_read, o_sram_addr, o_pix_data, o_pix_valid,
               o_frame_done, o_req_err
    );
    modport slave (
        output i_frame_start, i_pix_req, i_sram_data, i_scroll_y,
        input  o_sram_read, o_sram_addr, o_pix_data, o_pix_valid,
               o_frame_done, o_req_err
    );
`else
    modport master (
        input  i_frame_start, i_pix_req, i_sram_data,
        output o_sram_read, o_sram_addr, o_pix_data, o_pix_valid,
               o_frame_done, o_req_err
    );
    modport slave (
        output i_frame_start, i_pix_req, i_sram_data,
        input  o_sram_read, o_sram_addr, o_pix_data, o_pix_valid,
               o_frame_done, o_req_err
    );
`endif
endinterface

// File: rtl/framebuffer_reader.sv
// ---------------------------------------------------------------------------
// framebuffer_reader
//
// Read-side master of the dual-port framebuffer SRAM. Walks the buffer in
// raster order, issuing one SRAM read per display pixel requested, and
// replicates every pixel SCALE times horizontally and every line SCALE times
// vertically so a low-resolution buffer fills the screen.
//
// Ports:
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   bus    framebuffer_reader_if.master (pixel handshake + SRAM read port)
//
// Optional feature macro: FB_READER_SCROLL_EN. When defined the scan starts
// at framebuffer line i_scroll_y (sampled on i_frame_start, out-of-range
// values mean 0) and wraps from the bottom line back to line 0.
// ---------------------------------------------------------------------------
module framebuffer_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int SCALE      = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    framebuffer_reader_if.master  bus
);
    localparam int SW = (SCALE > 1)     ? $clog2(SCALE)     : 1;
    localparam int XW = (FB_WIDTH > 1)  ? $clog2(FB_WIDTH)  : 1;
    localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

    localparam logic [SW-1:0]         S_MAX  = SW'(SCALE - 1);
    localparam logic [XW-1:0]         X_MAX  = XW'(FB_WIDTH - 1);
    localparam logic [YW-1:0]         Y_MAX  = YW'(FB_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_W = ADDR_WIDTH'(FB_WIDTH);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         xSub_q, xSub_d;
    logic [XW-1:0]         x_q, x_d;
    logic [SW-1:0]         ySub_q, ySub_d;
    logic [YW-1:0]         y_q, y_d;
    logic [ADDR_WIDTH-1:0] lineBase_q, lineBase_d;
    logic                  reqErr_q, reqErr_d;
    logic                  pixValid_q;
    logic                  frameDone_q;

    logic                  sramRead;
    logic                  lastRead;
    logic [YW-1:0]         yStart;
    logic [YW-1:0]         yEnd;
    logic [ADDR_WIDTH-1:0] baseStart;

`ifdef FB_READER_SCROLL_EN
    logic [YW-1:0]         yLast_q, yLast_d;
    logic [YW-1:0]         yLastStart;

    // The frame begins at the requested line and its final displayed line is
    // the one just above it (modulo the buffer height), so the end line is
    // captured together with the start line.
    always_comb begin
        yStart     = (bus.i_scroll_y > Y_MAX) ? '0 : YW'(bus.i_scroll_y);
        yLastStart = (yStart == '0) ? Y_MAX : yStart - YW'(1);
        baseStart  = ADDR_WIDTH'(yStart) * LINE_W;
        yEnd       = yLast_q;
    end
`else
    // Without scrolling every frame runs from line 0 to the bottom line.
    always_comb begin
        yStart    = '0;
        baseStart = '0;
        yEnd      = Y_MAX;
    end
`endif

    // Next-state logic: decides whether a read is issued this cycle and
    // steps the nested replication/raster counters when it is. A frame
    // start overrides everything, including a simultaneous pixel request.
    always_comb begin
        state_d    = state_q;
        xSub_d     = xSub_q;
        x_d        = x_q;
        ySub_d     = ySub_q;
        y_d        = y_q;
        lineBase_d = lineBase_q;
        reqErr_d   = reqErr_q;
`ifdef FB_READER_SCROLL_EN
        yLast_d    = yLast_q;
`endif

        sramRead = (state_q == SCAN) && bus.i_pix_req && !bus.i_frame_start;
        lastRead = sramRead && (xSub_q == S_MAX) && (x_q == X_MAX) &&
                   (ySub_q == S_MAX) && (y_q == yEnd);

        if (bus.i_frame_start) begin
            state_d    = SCAN;
            xSub_d     = '0;
            x_d        = '0;
            ySub_d     = '0;
            y_d        = yStart;
            lineBase_d = baseStart;
            reqErr_d   = 1'b0;
`ifdef FB_READER_SCROLL_EN
            yLast_d    = yLastStart;
`endif
        end else begin
            if (bus.i_pix_req && (state_q != SCAN)) begin
                reqErr_d = 1'b1;
            end
            if (sramRead) begin
                xSub_d = (xSub_q == S_MAX) ? '0 : xSub_q + SW'(1);
                if (xSub_q == S_MAX) begin
                    x_d = (x_q == X_MAX) ? '0 : x_q + XW'(1);
                    if (x_q == X_MAX) begin
                        ySub_d = (ySub_q == S_MAX) ? '0 : ySub_q + SW'(1);
                        if (ySub_q == S_MAX) begin
                            if (y_q == Y_MAX) begin
                                y_d        = '0;
                                lineBase_d = '0;
                            end else begin
                                y_d        = y_q + YW'(1);
                                lineBase_d = lineBase_q + LINE_W;
                            end
                        end
                    end
                end
                if (lastRead) begin
                    state_d = DONE;
                end
            end
        end
    end

    // State and counter registers. The read strobe and last-read flag are
    // delayed by one cycle to line up with the SRAM's read latency; reset
    // drops them at once so an in-flight pixel never reaches the output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            xSub_q      <= '0;
            x_q         <= '0;
            ySub_q      <= '0;
            y_q         <= '0;
            lineBase_q  <= '0;
            reqErr_q    <= 1'b0;
            pixValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
`ifdef FB_READER_SCROLL_EN
            yLast_q     <= Y_MAX;
`endif
        end else begin
            state_q     <= state_d;
            xSub_q      <= xSub_d;
            x_q         <= x_d;
            ySub_q      <= ySub_d;
            y_q         <= y_d;
            lineBase_q  <= lineBase_d;
            reqErr_q    <= reqErr_d;
            pixValid_q  <= sramRead;
            frameDone_q <= lastRead;
`ifdef FB_READER_SCROLL_EN
            yLast_q     <= yLast_d;
`endif
        end
    end

    assign bus.o_sram_read  = sramRead;
    assign bus.o_sram_addr  = lineBase_q + ADDR_WIDTH'(x_q);
    assign bus.o_pix_data   = bus.i_sram_data;
    assign bus.o_pix_valid  = pixValid_q;
    assign bus.o_frame_done = frameDone_q;
    assign bus.o_req_err    = reqErr_q;
endmodule

// File: tb/tb_framebuffer_reader.sv
// ---------------------------------------------------------------------------
// tb_framebuffer_reader
//
// Self-checking bench for framebuffer_reader on a 4x3 buffer with 2x
// replication. Expected pixels come from a frame-level reference model that
// lists the address sequence of a whole frame; each issued read pushes its
// expected pixel into a scoreboard, and a monitor pops and compares whenever
// the reader presents a valid pixel.
// ---------------------------------------------------------------------------
module tb_framebuffer_reader;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int S  = 2;
    localparam int FRAME_READS = W * H * S * S;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        int            cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cycle;
    int   total;
    int   bad;

    exp_t sbq[$];
    int   seq[$];
    bit   mScan;
    bit   mErr;
    int   mIdx;

    framebuffer_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_HEIGHT(H)) bus ();

    framebuffer_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FB_WIDTH  (W),
        .FB_HEIGHT (H),
        .SCALE     (S)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Free-running clock with a 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to check the one-cycle read latency.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Distinct, easily recognised content for every framebuffer address.
    function automatic logic [DW-1:0] memVal(input int addr);
        return DW'((addr * 37 + 11) & 255);
    endfunction

    // Behavioural SRAM: data of the address read appears one cycle later.
    always @(posedge clk) begin
        if (bus.o_sram_read) begin
            bus.i_sram_data <= memVal(int'(bus.o_sram_addr));
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Address list of one frame: displayed lines start at y0 and wrap, each
    // line shown S times, each pixel shown S times.
    task automatic buildFrame(input int scroll);
        int y0;
        y0 = (scroll >= H) ? 0 : scroll;
        seq.delete();
        for (int l = 0; l < H; l++) begin
            for (int ys = 0; ys < S; ys++) begin
                for (int x = 0; x < W; x++) begin
                    for (int xs = 0; xs < S; xs++) begin
                        seq.push_back(((y0 + l) % H) * W + x);
                    end
                end
            end
        end
    endtask

    // Drives one cycle of inputs, checks the immediate read decision, and
    // advances the reference model.
    task automatic applyStimulus(input bit req, input bit fs, input int scroll);
        bit   expRead;
        exp_t e;
        @(negedge clk);
        bus.i_pix_req     = req;
        bus.i_frame_start = fs;
`ifdef FB_READER_SCROLL_EN
        bus.i_scroll_y    = 2'(scroll);
`endif
        #1;
        expRead = mScan && req && !fs;
        checkOutput("sram_read", bus.o_sram_read, expRead);
        checkOutput("req_err", bus.o_req_err, mErr);
        if (expRead) begin
            checkOutput("sram_addr", bus.o_sram_addr, seq[mIdx]);
        end
        if (fs) begin
            mScan = 1'b1;
            mErr  = 1'b0;
            mIdx  = 0;
`ifdef FB_READER_SCROLL_EN
            buildFrame(scroll);
`else
            buildFrame(0);
`endif
        end else if (req) begin
            if (mScan) begin
                e.data = memVal(seq[mIdx]);
                e.last = (mIdx == FRAME_READS - 1);
                e.cyc  = cycle + 1;
                sbq.push_back(e);
                mIdx++;
                if (mIdx == FRAME_READS) mScan = 1'b0;
            end else begin
                mErr = 1'b1;
            end
        end
    endtask

    // Asserts reset just after a clock edge so that a pixel registered at
    // that edge is still in flight and must be suppressed.
    task automatic applyReset();
        @(posedge clk);
        #1;
        rst               = 1'b1;
        bus.i_pix_req     = 1'b0;
        bus.i_frame_start = 1'b0;
        #1;
        checkOutput("rst_pix_valid", bus.o_pix_valid, 0);
        checkOutput("rst_frame_done", bus.o_frame_done, 0);
        checkOutput("rst_req_err", bus.o_req_err, 0);
        checkOutput("rst_sram_read", bus.o_sram_read, 0);
        checkOutput("rst_sram_addr", bus.o_sram_addr, 0);
        sbq.delete();
        mScan = 1'b0;
        mErr  = 1'b0;
        mIdx  = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every valid pixel must match the oldest expected
    // pixel in data, frame-done flag and arrival cycle; frame_done may never
    // appear without a pixel.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_pix_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_pix_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("pix_data", bus.o_pix_data, e.data);
                    checkOutput("frame_done", bus.o_frame_done, e.last);
                    checkOutput("pix_latency", cycle, e.cyc);
                end
            end else if (bus.o_frame_done) begin
                checkOutput("frame_done_no_valid", 1, 0);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        cycle = 0;
        mScan = 1'b0;
        mErr  = 1'b0;
        mIdx  = 0;
        rst               = 1'b1;
        bus.i_pix_req     = 1'b0;
        bus.i_frame_start = 1'b0;
        bus.i_sram_data   = '0;
`ifdef FB_READER_SCROLL_EN
        bus.i_scroll_y    = '0;
`endif
        buildFrame(0);
        repeat (3) @(negedge clk);
        checkOutput("init_pix_valid", bus.o_pix_valid, 0);
        checkOutput("init_req_err", bus.o_req_err, 0);
        checkOutput("init_sram_addr", bus.o_sram_addr, 0);
        rst = 1'b0;

        // Full frame with back-to-back requests.
        applyStimulus(0, 1, 0);
        for (int i = 0; i < FRAME_READS; i++) applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);

        // Request after the frame is done, then clear with a frame start.
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 0);

        // Alternating requests over a whole frame.
        for (int i = 0; i < 2 * FRAME_READS; i++) applyStimulus(i % 2 == 0, 0, 0);
        applyStimulus(0, 0, 0);

        // Restart after 10 reads with a same-cycle request, then a full frame.
        applyStimulus(0, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        for (int i = 0; i < FRAME_READS; i++) applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);

`ifdef FB_READER_SCROLL_EN
        // Scrolled frame starting at line 2.
        applyStimulus(0, 1, 2);
        for (int i = 0; i < FRAME_READS; i++) applyStimulus(1, 0, 2);
        applyStimulus(0, 0, 0);
`endif

        // Randomised traffic with occasional restarts.
        for (int i = 0; i < 800; i++) begin
            bit fs;
            fs = mScan ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 4) == 0);
            applyStimulus($urandom_range(0, 9) < 7, fs, int'($urandom_range(0, 3)));
        end

        // Reset mid-scan with a pixel in flight, then a request while idle.
        applyStimulus(0, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
        applyReset();
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
